truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequential stimulus/check stage that sits directly upstream and downstream of the 4-input gate-level function F(w,x,y,z) = w'z + xz + x'y + wx'z.
- It drives all 16 input combinations in ascending minterm order and samples the returned F for each one.
- It compares each sample against a parameterised expected truth table and reports pass/fail, an error count, the first failing minterm and a per-minterm failure map.
- Used in-system as a built-in self-check for the combinational quiz circuits.

Parameters:
EXPECTED, 16'hAEAE, expected F per minterm; bit m = F for {w,x,y,z} = m (w is MSB). 16'hAEAE is F = z + x'y.
SETTLE, 1, clock cycles each vector is held; integer >= 1; F is sampled on the last edge of the hold window.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  begin a sweep; accepted only in IDLE
abort  input  1  synchronous abort of a running sweep
f_in  input  1  F returned from the function under test
w  output  1  stimulus bit 3 (vec[3])
x  output  1  stimulus bit 2 (vec[2])
y  output  1  stimulus bit 1 (vec[1])
z  output  1  stimulus bit 0 (vec[0])
busy  output  1  sweep in progress
done  output  1  one-cycle pulse after the final sample
pass  output  1  last completed sweep had zero mismatches
err_count  output  5  mismatches in the current/last sweep (0..16)
first_fail  output  4  lowest failing minterm; valid when fail_valid=1
fail_valid  output  1  at least one mismatch recorded
fail_map  output  16  bit m set if minterm m mismatched

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: all outputs 0, including w/x/y/z, busy, done, pass, err_count, first_fail, fail_valid and fail_map. State = IDLE, hold counter = 0.
- rst has priority over every other input in every state. Reset mid-sweep discards all partial results and emits no done pulse.
- States: IDLE and RUN. All outputs are registered.
- IDLE, start=1, abort=0 at an edge:
  - go to RUN; vec=0; hold counter=0; busy=1.
  - clear err_count, fail_map, fail_valid, first_fail and pass.
- IDLE with abort=1: stay in IDLE; start is ignored.
- RUN, each edge:
  - if abort=1: go to IDLE, busy=0, vec=0, no done pulse, pass=0; partial err_count and fail_map are retained.
  - else if hold counter < SETTLE-1: increment the hold counter.
  - else (sample edge): compare f_in with EXPECTED[vec]. On mismatch:
    - err_count += 1; fail_map[vec] = 1.
    - if fail_valid=0: first_fail = vec and fail_valid = 1.
  - After the sample edge, if vec < 15: vec += 1 and hold counter = 0.
  - If the sample was for vec = 15: go to IDLE; busy=0; vec=0; done=1 for exactly one cycle; pass = 1 iff the final err_count (including this sample) is 0.
- start is ignored while busy=1; no restart and no counter disturbance.
- Latency: the sweep runs for exactly 16*SETTLE cycles from the start-accept edge to the edge that raises done.
- Results (pass, err_count, first_fail, fail_valid, fail_map) hold until the next accepted start or rst.
- err_count saturation is not needed: the maximum is 16, which fits in 5 bits.
- A new start may be accepted on the cycle done is high, because the state is already IDLE.
- The function under test is combinational; F settles within one cycle of a vec change.

Test Plan:
- Correct F gate-level circuit connected, SETTLE=1, start pulsed -> w/x/y/z step through 0..15 on consecutive cycles; done 16 cycles after the accept edge; pass=1, err_count=0, fail_valid=0, fail_map=16'h0000.
- f_in = inverted F -> err_count=16, first_fail=0, fail_valid=1, fail_map=16'hFFFF, pass=0.
- f_in = F with minterm 6 forced to 1 (fault injection) -> err_count=1, first_fail=6, fail_map=16'h0040, pass=0.
- SETTLE=3 with the correct circuit -> each vector held 3 cycles; done 48 cycles after accept; start pulsed at vec=4 is ignored, and the sweep still ends with pass=1.
- rst asserted while vec=5 -> next cycle all outputs are 0 and the state is IDLE; no done pulse. A subsequent start runs a full clean sweep with pass=1.
- abort at vec=9 with f_in inverted -> busy=0, done never pulses, pass=0, err_count=9, fail_map=16'h01FF.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Built-in self-check for a 4-input combinational function: sweeps all 16 minterms,
// samples F at the end of each hold window and records mismatches against EXPECTED.
module truth_table_sweeper #(
  parameter logic [15:0] EXPECTED = 16'hAEAE,
  parameter int          SETTLE   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [3:0]  first_fail,
  output logic        fail_valid,
  output logic [15:0] fail_map
);

  localparam int HW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_r, state_s;
  logic [3:0]    vec_r, vec_s;
  logic [HW-1:0] hold_r, hold_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          pass_r, pass_s;
  logic [4:0]    err_r, err_s;
  logic [3:0]    ff_r, ff_s;
  logic          fv_r, fv_s;
  logic [15:0]   map_r, map_s;
  logic          mismatch_s;

  // Next-state and result update logic for the sweep FSM.
  always_comb begin
    state_s    = state_r;
    vec_s      = vec_r;
    hold_s     = hold_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    pass_s     = pass_r;
    err_s      = err_r;
    ff_s       = ff_r;
    fv_s       = fv_r;
    map_s      = map_r;
    mismatch_s = (f_in != EXPECTED[vec_r]);
    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          state_s = RUN;
          vec_s   = 4'd0;
          hold_s  = '0;
          busy_s  = 1'b1;
          pass_s  = 1'b0;
          err_s   = 5'd0;
          ff_s    = 4'd0;
          fv_s    = 1'b0;
          map_s   = 16'h0000;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          // Partial error count and map stay visible for diagnosis.
          state_s = IDLE;
          busy_s  = 1'b0;
          vec_s   = 4'd0;
          hold_s  = '0;
          pass_s  = 1'b0;
        end else if (hold_r != HW'(SETTLE - 1)) begin
          hold_s = hold_r + HW'(1);
        end else begin
          if (mismatch_s) begin
            err_s        = err_r + 5'd1;
            map_s[vec_r] = 1'b1;
            if (!fv_r) begin
              ff_s = vec_r;
              fv_s = 1'b1;
            end else begin
              ff_s = ff_r;
            end
          end else begin
            err_s = err_r;
          end
          hold_s = '0;
          if (vec_r != 4'd15) begin
            vec_s = vec_r + 4'd1;
          end else begin
            state_s = IDLE;
            busy_s  = 1'b0;
            vec_s   = 4'd0;
            done_s  = 1'b1;
            pass_s  = (err_s == 5'd0);
          end
        end
      end
      default: begin
        state_s = IDLE;
        vec_s   = 4'd0;
        hold_s  = '0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      vec_r   <= 4'd0;
      hold_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      err_r   <= 5'd0;
      ff_r    <= 4'd0;
      fv_r    <= 1'b0;
      map_r   <= 16'h0000;
    end else begin
      state_r <= state_s;
      vec_r   <= vec_s;
      hold_r  <= hold_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
      err_r   <= err_s;
      ff_r    <= ff_s;
      fv_r    <= fv_s;
      map_r   <= map_s;
    end
  end

  assign {w, x, y, z} = vec_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign pass         = pass_r;
  assign err_count    = err_r;
  assign first_fail   = ff_r;
  assign fail_valid   = fv_r;
  assign fail_map     = map_r;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a gate-level F model (optionally faulted) feeds two
// instances (SETTLE=1 and SETTLE=3); sweep results are checked against a scoreboard.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, sel;
  logic [1:0] mode;
  logic       start1, abort1, start3, abort3;

  logic        w1, x1, y1, z1, busy1, done1, pass1, fv1, f1;
  logic [4:0]  err1;
  logic [3:0]  ff1;
  logic [15:0] map1;
  logic        w3, x3, y3, z3, busy3, done3, pass3, fv3, f3;
  logic [4:0]  err3;
  logic [3:0]  ff3;
  logic [15:0] map3;

  logic [3:0]  cur_vec, cur_ff;
  logic        cur_busy, cur_done, cur_pass, cur_fv;
  logic [4:0]  cur_err;
  logic [15:0] cur_map;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [4:0]  err;
    logic [3:0]  ff;
    logic        fv;
    logic [15:0] map;
    logic        pass;
  } vec_t;

  vec_t tbl[3];
  vec_t exp_q[$];
  vec_t e;

  // mode 0: correct F, mode 1: inverted F, mode 2: minterm 6 stuck at 1
  function automatic logic fmodel(input logic [3:0] v, input logic [1:0] m);
    logic fw, fx, fy, fz, f;
    {fw, fx, fy, fz} = v;
    f = (~fw & fz) | (fx & fz) | (~fx & fy) | (fw & ~fx & fz);
    case (m)
      2'd1:    f = ~f;
      2'd2:    f = (v == 4'd6) ? 1'b1 : f;
      default: f = f;
    endcase
    return f;
  endfunction

  assign f1     = fmodel({w1, x1, y1, z1}, mode);
  assign f3     = fmodel({w3, x3, y3, z3}, mode);
  assign start1 = start & ~sel;
  assign abort1 = abort & ~sel;
  assign start3 = start & sel;
  assign abort3 = abort & sel;

  always_comb begin
    if (sel) begin
      cur_vec = {w3, x3, y3, z3}; cur_busy = busy3; cur_done = done3; cur_pass = pass3;
      cur_err = err3; cur_ff = ff3; cur_fv = fv3; cur_map = map3;
    end else begin
      cur_vec = {w1, x1, y1, z1}; cur_busy = busy1; cur_done = done1; cur_pass = pass1;
      cur_err = err1; cur_ff = ff1; cur_fv = fv1; cur_map = map1;
    end
  end

  truth_table_sweeper #(.EXPECTED(16'hAEAE), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .f_in(f1),
    .w(w1), .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1), .fail_valid(fv1), .fail_map(map1)
  );

  truth_table_sweeper #(.EXPECTED(16'hAEAE), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3), .f_in(f3),
    .w(w3), .x(x3), .y(y3), .z(z3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_fail(ff3), .fail_valid(fv3), .fail_map(map3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int settle, input int poke);
    int cyc;
    cyc = 1;
    while (!cur_done && cyc <= 16 * settle + 4) begin
      chk("vec_step", cur_vec, (cyc - 1) / settle);
      if (poke >= 0 && cur_vec == poke && ((cyc - 1) % settle) == 0) start = 1'b1;
      else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_latency", cyc, 16 * settle + 1);
    chk("done_state", {cur_done, cur_busy, cur_vec}, {1'b1, 1'b0, 4'd0});
    @(negedge clk);
    chk("done_pulse_width", cur_done, 1'b0);
  endtask

  task automatic chk_results(input string tag);
    e = exp_q.pop_front();
    chk({tag, "_err_count"}, cur_err, e.err);
    chk({tag, "_first_fail"}, cur_ff, e.ff);
    chk({tag, "_fail_valid"}, cur_fv, e.fv);
    chk({tag, "_fail_map"}, cur_map, e.map);
    chk({tag, "_pass"}, cur_pass, e.pass);
  endtask

  initial begin
    int k;
    logic seen;
    tbl[0] = '{mode: 2'd1, err: 5'd16, ff: 4'd0, fv: 1'b1, map: 16'hFFFF, pass: 1'b0};
    tbl[1] = '{mode: 2'd2, err: 5'd1,  ff: 4'd6, fv: 1'b1, map: 16'h0040, pass: 1'b0};
    tbl[2] = '{mode: 2'd0, err: 5'd0,  ff: 4'd0, fv: 1'b0, map: 16'h0000, pass: 1'b1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; sel = 1'b0; mode = 2'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_s1", {cur_vec, cur_busy, cur_done, cur_pass, cur_err, cur_ff, cur_fv, cur_map}, 64'd0);
    sel = 1'b1;
    #1;
    chk("reset_outputs_s3", {cur_vec, cur_busy, cur_done, cur_pass, cur_err, cur_ff, cur_fv, cur_map}, 64'd0);
    sel = 1'b0;
    rst = 1'b0;

    // start together with abort in IDLE must be ignored
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_blocks_start", cur_busy, 1'b0);

    for (int i = 0; i < 3; i++) begin
      mode = tbl[i].mode;
      exp_q.push_back(tbl[i]);
      do_start();
      wait_done(1, -1);
      chk_results("table");
    end

    // SETTLE=3 with a stray start at vec 4
    sel = 1'b1; mode = 2'd0;
    exp_q.push_back(tbl[2]);
    do_start();
    wait_done(3, 4);
    chk_results("settle3");
    sel = 1'b0;

    // abort at vec 9 with inverted F
    mode = 2'd1;
    exp_q.push_back('{mode: 2'd1, err: 5'd9, ff: 4'd0, fv: 1'b1, map: 16'h01FF, pass: 1'b0});
    do_start();
    k = 0;
    while (cur_vec != 4'd9 && k < 40) begin
      @(negedge clk);
      k++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_state", {cur_busy, cur_done, cur_vec}, {1'b0, 1'b0, 4'd0});
    chk_results("abort");
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (cur_done) seen = 1'b1;
    end
    chk("abort_no_done", seen, 1'b0);

    // reset at vec 5, then a clean sweep
    mode = 2'd0;
    do_start();
    k = 0;
    while (cur_vec != 4'd5 && k < 40) begin
      @(negedge clk);
      k++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midsweep_reset_outputs", {cur_vec, cur_busy, cur_done, cur_pass, cur_err, cur_ff, cur_fv, cur_map}, 64'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (cur_done) seen = 1'b1;
    end
    chk("reset_no_done", seen, 1'b0);
    exp_q.push_back(tbl[2]);
    do_start();
    wait_done(1, -1);
    chk_results("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
